// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction
// fetch port and the data port. Data accesses win, but a run of at most
// MAX_DATA_RUN data grants is allowed while a fetch waits. Hung transfers
// are aborted after TIMEOUT_CYCLES busy cycles without an acknowledge.
module mem_bus_arbiter #(
  parameter int MAX_DATA_RUN   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  output logic        stallreq_o
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);
  localparam logic [7:0]       TMO_MAX = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic             act_q, act_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       sel_q, sel_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic             if_ack_q, if_ack_d;
  logic             mem_ack_q, mem_ack_d;
  logic             err_q, err_d;

  // Next-state logic: grant in IDLE, complete or abort in the busy states.
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    act_d       = act_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        // The cycle carrying an ack is the turnaround cycle: the requester
        // still shows its old request then, so no grant is made.
        if (!(if_ack_q || mem_ack_q)) begin
          if (mem_req_i && (!if_req_i || (run_cnt_q < RUN_MAX))) begin
            state_d   = MEM_BUSY;
            act_d     = 1'b1;
            we_d      = mem_we_i;
            addr_d    = mem_addr_i;
            wdata_d   = mem_wdata_i;
            sel_d     = mem_sel_i;
            tmo_cnt_d = 8'd0;
            if (run_cnt_q != RUN_MAX) begin
              run_cnt_d = run_cnt_q + RUN_W'(1);
            end
          end else if (if_req_i) begin
            state_d   = IF_BUSY;
            act_d     = 1'b1;
            we_d      = 1'b0;
            addr_d    = if_addr_i;
            wdata_d   = 32'd0;
            sel_d     = 4'b1111;
            tmo_cnt_d = 8'd0;
            run_cnt_d = '0;
          end
        end
      end
      IF_BUSY, MEM_BUSY: begin
        if (bus_ack_i || (tmo_cnt_q == TMO_MAX)) begin
          // An abort looks like a completion with zero read data plus err.
          state_d = IDLE;
          act_d   = 1'b0;
          err_d   = !bus_ack_i;
          if (!if_req_i) begin
            run_cnt_d = '0;
          end
          if (state_q == IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_ack_i ? bus_rdata_i : 32'd0;
          end else begin
            mem_ack_d = 1'b1;
            if (!bus_ack_i) begin
              mem_rdata_d = 32'd0;
            end else if (!we_q) begin
              mem_rdata_d = bus_rdata_i;
            end
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        act_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      tmo_cnt_q   <= 8'd0;
      act_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      sel_q       <= 4'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      act_q       <= act_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sel_q       <= sel_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      err_q       <= err_d;
    end
  end

  assign bus_cyc_o   = act_q;
  assign bus_stb_o   = act_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_sel_o   = sel_q;
  assign bus_err_o   = err_q;
  assign if_rdata_o  = if_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;
  assign stallreq_o  = (if_req_i & ~if_ack_q) | (mem_req_i & ~mem_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by random
// requester/slave traffic checked against a cycle-level behavioural model.
module tb_mem_bus_arbiter;

  localparam int MAX_RUN = 4;
  localparam int TMO     = 255;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;
  logic        stallreq_o;

  mem_bus_arbiter #(.MAX_DATA_RUN(MAX_RUN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i), .mem_rdata_o(mem_rdata_o),
    .mem_ack_o(mem_ack_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i), .bus_err_o(bus_err_o),
    .stallreq_o(stallreq_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Slave: acks after slave_wait strobe cycles, or never when slave_never.
  int          slave_wait  = 0;
  bit          slave_never = 0;
  logic [31:0] slave_data  = 32'd0;
  int          wcnt        = 0;

  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = 32'd0;
    forever begin
      @(negedge clk);
      if (bus_ack_i) begin
        bus_ack_i = 1'b0;
        wcnt      = 0;
      end else if (!bus_stb_o) begin
        wcnt = 0;
      end else if (!slave_never && wcnt >= slave_wait) begin
        bus_ack_i   = 1'b1;
        bus_rdata_i = slave_data;
      end else begin
        wcnt++;
      end
    end
  end

  // Reference model: what the bus should look like after each edge.
  bit          m_busy, m_port, m_turn, m_we;
  int          m_tmo, m_streak;
  logic [31:0] m_addr, m_wdata, m_ifr, m_memr;
  logic [3:0]  m_sel;

  task automatic model_step();
    bit e_ifack, e_memack, e_err;
    e_ifack = 0; e_memack = 0; e_err = 0;
    if (!rst) begin
      m_busy = 0; m_port = 0; m_turn = 0; m_we = 0; m_tmo = 0; m_streak = 0;
      m_addr = 0; m_wdata = 0; m_sel = 0; m_ifr = 0; m_memr = 0;
    end else if (m_busy) begin
      if (bus_ack_i || m_tmo == TMO) begin
        m_busy = 0;
        e_err  = !bus_ack_i;
        if (m_port) begin
          e_memack = 1;
          if (!bus_ack_i) m_memr = 0;
          else if (!m_we) m_memr = bus_rdata_i;
        end else begin
          e_ifack = 1;
          m_ifr   = bus_ack_i ? bus_rdata_i : 32'd0;
        end
        if (!if_req_i) m_streak = 0;
      end else begin
        m_tmo++;
      end
    end else if (!m_turn) begin
      if (mem_req_i && (!if_req_i || m_streak < MAX_RUN)) begin
        m_busy = 1; m_port = 1; m_tmo = 0;
        m_we = mem_we_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i; m_sel = mem_sel_i;
        if (m_streak < MAX_RUN) m_streak++;
      end else if (if_req_i) begin
        m_busy = 1; m_port = 0; m_tmo = 0; m_streak = 0;
        m_we = 0; m_addr = if_addr_i; m_sel = 4'b1111;
      end
    end
    m_turn = e_ifack | e_memack;
    chk("cyc", 32'(bus_cyc_o), 32'(m_busy));
    chk("stb", 32'(bus_stb_o), 32'(m_busy));
    chk("if_ack", 32'(if_ack_o), 32'(e_ifack));
    chk("mem_ack", 32'(mem_ack_o), 32'(e_memack));
    chk("bus_err", 32'(bus_err_o), 32'(e_err));
    chk("if_rdata", if_rdata_o, m_ifr);
    chk("mem_rdata", mem_rdata_o, m_memr);
    chk("stallreq", 32'(stallreq_o),
        32'((if_req_i & ~e_ifack) | (mem_req_i & ~e_memack)));
    if (!rst || m_busy) begin
      chk("bus_addr", bus_addr_o, m_addr);
      chk("bus_we", 32'(bus_we_o), 32'(m_we));
      chk("bus_sel", 32'(bus_sel_o), 32'(m_sel));
    end
    if (!rst || (m_busy && m_we)) chk("bus_wdata", bus_wdata_o, m_wdata);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      model_step();
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic at_edge();
    @(posedge clk);
    #2;
  endtask

  // Observation of one requester over a window of cycles (cycle 1 = now).
  int          w_stb_at, w_ack_at, w_ack_n, w_stall_n, w_err_at, w_err_n;
  int          w_stb_n, w_stb_late, w_hold_bad;
  logic [31:0] w_rdata, w_addr, w_wdata;
  logic        w_we;
  logic [3:0]  w_sel;

  task automatic watch(input bit port, input int ncyc, input bit wd);
    w_stb_at = 0; w_ack_at = 0; w_ack_n = 0; w_stall_n = 0; w_err_at = 0; w_err_n = 0;
    w_stb_n = 0; w_stb_late = 0; w_hold_bad = 0; w_rdata = 0;
    w_addr = 0; w_wdata = 0; w_we = 0; w_sel = 0;
    for (int i = 1; i <= ncyc; i++) begin
      bit ackd, drop;
      @(negedge clk);
      ackd = port ? mem_ack_o : if_ack_o;
      if (stallreq_o) w_stall_n++;
      if (bus_stb_o) begin
        if (w_stb_n == 0) begin
          w_stb_at = i; w_addr = bus_addr_o; w_wdata = bus_wdata_o;
          w_we = bus_we_o; w_sel = bus_sel_o;
        end else if (bus_addr_o !== w_addr || bus_wdata_o !== w_wdata ||
                     bus_we_o !== w_we || bus_sel_o !== w_sel) begin
          w_hold_bad++;
        end
        w_stb_n++;
        if (w_ack_n > 0) w_stb_late++;
      end
      if (ackd) begin
        w_ack_n++;
        if (w_ack_at == 0) w_ack_at = i;
        w_rdata = port ? mem_rdata_o : if_rdata_o;
      end
      if (bus_err_o) begin
        w_err_n++;
        if (w_err_at == 0) w_err_at = i;
      end
      drop = ackd || (wd && bus_stb_o);
      @(posedge clk);
      #2;
      if (drop) begin
        if (port) mem_req_i = 1'b0;
        else begin
          if_req_i  = 1'b0;
          if_addr_i = ~if_addr_i;
        end
      end
    end
  endtask

  initial begin
    int n, dual, acks;
    bit ord [10];
    rst = 1'b0; if_req_i = 0; if_addr_i = 0; mem_req_i = 0; mem_we_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0;

    // Reset state
    repeat (3) at_edge();
    @(negedge clk);
    chk("rst_cyc", 32'(bus_cyc_o), 0);
    chk("rst_stb", 32'(bus_stb_o), 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_acks", 32'({if_ack_o, mem_ack_o, bus_err_o}), 0);
    chk("rst_rdata", if_rdata_o | mem_rdata_o, 0);
    at_edge();
    rst = 1'b1;
    at_edge();

    // Single load with a zero-wait slave
    slave_wait = 0; slave_data = 32'hDEADBEEF;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h0000_0010; mem_sel_i = 4'b1111;
    watch(1, 6, 0);
    chk("load_stb_at", w_stb_at, 2);
    chk("load_ack_at", w_ack_at, 3);
    chk("load_ack_n", w_ack_n, 1);
    chk("load_rdata", w_rdata, 32'hDEADBEEF);
    chk("load_stall", w_stall_n, 2);
    chk("load_addr", w_addr, 32'h10);

    // Store with a 2-wait slave
    slave_wait = 2; slave_data = 32'hFFFF_0000;
    mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h20; mem_wdata_i = 32'h12345678;
    mem_sel_i = 4'b0011;
    watch(1, 8, 0);
    chk("store_we", 32'(w_we), 1);
    chk("store_sel", 32'(w_sel), 32'h3);
    chk("store_wdata", w_wdata, 32'h12345678);
    chk("store_addr", w_addr, 32'h20);
    chk("store_hold", w_hold_bad, 0);
    chk("store_stb_n", w_stb_n, 3);
    chk("store_ack_n", w_ack_n, 1);
    chk("store_ack_at", w_ack_at, 5);
    chk("store_rdata", mem_rdata_o, 32'hDEADBEEF);

    // Contention: both requesters held continuously
    slave_wait = 0; slave_data = 32'h1357_9BDF;
    mem_we_i = 0; mem_addr_i = 32'h100; if_addr_i = 32'h200;
    if_req_i = 1; mem_req_i = 1;
    n = 0; dual = 0;
    for (int i = 0; i < 80 && n < 10; i++) begin
      @(negedge clk);
      if (if_ack_o && mem_ack_o) dual++;
      if (mem_ack_o) begin ord[n] = 1; n++; end
      else if (if_ack_o) begin ord[n] = 0; n++; end
      @(posedge clk);
      #2;
    end
    if_req_i = 0; mem_req_i = 0;
    chk("cont_n", n, 10);
    chk("cont_dual", dual, 0);
    for (int k = 0; k < 10; k++)
      chk($sformatf("cont_order%0d", k), 32'(ord[k]), (k % 5 == 4) ? 32'd0 : 32'd1);
    at_edge();

    // Timeout on a fetch to a slave that never acks
    slave_never = 1;
    if_req_i = 1; if_addr_i = 32'h0000_0400;
    watch(0, 262, 0);
    chk("tmo_stb_at", w_stb_at, 2);
    chk("tmo_ack_at", w_ack_at, 258);
    chk("tmo_err_at", w_err_at, 258);
    chk("tmo_err_n", w_err_n, 1);
    chk("tmo_ack_n", w_ack_n, 1);
    chk("tmo_rdata", w_rdata, 0);
    chk("tmo_cyc_after", w_stb_late, 0);
    slave_never = 0;

    // Fetch withdrawn one cycle after grant
    slave_wait = 2; slave_data = 32'hCAFE_F00D;
    if_req_i = 1; if_addr_i = 32'h0000_0800;
    watch(0, 10, 1);
    chk("wd_ack_n", w_ack_n, 1);
    chk("wd_ack_at", w_ack_at, 5);
    chk("wd_hold", w_hold_bad, 0);
    chk("wd_stb_late", w_stb_late, 0);
    chk("wd_rdata", w_rdata, 32'hCAFE_F00D);

    // Asynchronous reset during a data transaction
    slave_never = 1;
    mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h40;
    repeat (3) @(negedge clk);
    chk("arst_pre_cyc", 32'(bus_cyc_o), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cyc", 32'(bus_cyc_o), 0);
    chk("arst_stb", 32'(bus_stb_o), 0);
    mem_req_i = 0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_ack_o) acks++;
    end
    chk("arst_no_ack", acks, 0);
    at_edge();
    rst = 1'b1; slave_never = 0; slave_wait = 0; slave_data = 32'h0BAD_CAFE;
    at_edge();
    mem_req_i = 1;
    watch(1, 8, 0);
    chk("arst_after_ack_n", w_ack_n, 1);
    chk("arst_after_ack_at", w_ack_at, 3);
    chk("arst_after_rdata", w_rdata, 32'h0BAD_CAFE);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bit ia, ma;
      @(negedge clk);
      ia = if_ack_o; ma = mem_ack_o;
      @(posedge clk);
      #2;
      slave_wait = $urandom_range(0, 3);
      slave_data = $urandom;
      if (!if_req_i || ia) begin
        if_req_i  = ($urandom_range(0, 1) == 1);
        if_addr_i = $urandom;
      end
      if (!mem_req_i || ma) begin
        mem_req_i   = ($urandom_range(0, 1) == 1);
        mem_we_i    = ($urandom_range(0, 1) == 1);
        mem_addr_i  = $urandom;
        mem_wdata_i = $urandom;
        mem_sel_i   = 4'($urandom_range(0, 15));
      end
    end
    if_req_i = 0; mem_req_i = 0;
    repeat (8) at_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
